// File: rtl/ins_mem_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port between fetch (m0)
// and loader/debug (m1); one access in flight, watchdog turns silence into an error.
module ins_mem_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clock_in,
    input  logic            reset_in,
    input  logic            m0_valid_in,
    input  logic [XLEN-1:0] m0_addr_in,
    output logic            m0_ready_out,
    output logic [XLEN-1:0] m0_data_out,
    output logic            m0_err_out,
    input  logic            m1_valid_in,
    input  logic [XLEN-1:0] m1_addr_in,
    output logic            m1_ready_out,
    output logic [XLEN-1:0] m1_data_out,
    output logic            m1_err_out,
    output logic            mem_valid_out,
    output logic [XLEN-1:0] mem_addr_out,
    input  logic            mem_ready_in,
    input  logic [XLEN-1:0] mem_data_in
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_grant_q, last_grant_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] resp_q, resp_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            grant;

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            resp_q       <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            resp_q       <= resp_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        resp_d       = resp_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        // On a tie the master not served last wins; a lone requester always wins.
        grant        = (m0_valid_in && m1_valid_in) ? ~last_grant_q : m1_valid_in;

        case (state_q)
            IDLE: begin
                if (m0_valid_in || m1_valid_in) begin
                    owner_d = grant;
                    addr_d  = grant ? m1_addr_in : m0_addr_in;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready_in) begin
                    resp_d  = mem_data_in;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    resp_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                last_grant_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Every output comes from registers so no input reaches an output combinationally.
    assign mem_valid_out = (state_q == BUSY);
    assign mem_addr_out  = addr_q;
    assign m0_ready_out  = (state_q == RESP) && !owner_q;
    assign m1_ready_out  = (state_q == RESP) && owner_q;
    assign m0_err_out    = m0_ready_out && err_q;
    assign m1_err_out    = m1_ready_out && err_q;
    assign m0_data_out   = resp_q;
    assign m1_data_out   = resp_q;

endmodule

// File: tb/tb_ins_mem_arbiter.sv
// Self-checking bench for ins_mem_arbiter: directed scenarios followed by random
// transactions compared against a transaction-level reference model.
module tb_ins_mem_arbiter;
    localparam int XLEN    = 32;
    localparam int TIMEOUT = 16;

    logic            clock_in = 1'b0;
    logic            reset_in;
    logic            m0_valid_in, m1_valid_in;
    logic [XLEN-1:0] m0_addr_in, m1_addr_in;
    logic            m0_ready_out, m1_ready_out;
    logic [XLEN-1:0] m0_data_out, m1_data_out;
    logic            m0_err_out, m1_err_out;
    logic            mem_valid_out;
    logic [XLEN-1:0] mem_addr_out;
    logic            mem_ready_in;
    logic [XLEN-1:0] mem_data_in;

    ins_mem_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clock_in     (clock_in),
        .reset_in     (reset_in),
        .m0_valid_in  (m0_valid_in),
        .m0_addr_in   (m0_addr_in),
        .m0_ready_out (m0_ready_out),
        .m0_data_out  (m0_data_out),
        .m0_err_out   (m0_err_out),
        .m1_valid_in  (m1_valid_in),
        .m1_addr_in   (m1_addr_in),
        .m1_ready_out (m1_ready_out),
        .m1_data_out  (m1_data_out),
        .m1_err_out   (m1_err_out),
        .mem_valid_out(mem_valid_out),
        .mem_addr_out (mem_addr_out),
        .mem_ready_in (mem_ready_in),
        .mem_data_in  (mem_data_in)
    );

    always #5 clock_in = ~clock_in;

    int          vecs = 0;
    int          errs = 0;
    int          exp_last = 1;          // master served most recently
    logic [31:0] exp_resp = '0;         // last response value delivered

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vecs++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called at the falling edge of an IDLE cycle; returns at the falling edge of the next IDLE cycle.
    task automatic do_txn(input bit v0, input bit v1, input logic [31:0] a0, input logic [31:0] a1,
                          input int waits, input logic [31:0] rdata, input bit perturb, input bit late);
        int          win;
        int          nb;
        bit          tmo;
        logic [31:0] waddr;
        check("idle_mem_valid", {31'b0, mem_valid_out}, 32'd0);
        check("idle_ready", {30'b0, m1_ready_out, m0_ready_out}, 32'd0);
        check("idle_data0", m0_data_out, exp_resp);
        check("idle_data1", m1_data_out, exp_resp);
        win   = (v0 && v1) ? ((exp_last == 1) ? 0 : 1) : (v0 ? 0 : 1);
        tmo   = (waits >= TIMEOUT);
        nb    = tmo ? TIMEOUT : waits + 1;
        waddr = (win == 0) ? a0 : a1;
        m0_valid_in  = v0;
        m1_valid_in  = v1;
        m0_addr_in   = a0;
        m1_addr_in   = a1;
        mem_ready_in = 1'b0;
        mem_data_in  = $urandom;
        @(negedge clock_in);
        for (int i = 0; i < nb; i++) begin
            check("busy_mem_valid", {31'b0, mem_valid_out}, 32'd1);
            check("busy_mem_addr", mem_addr_out, waddr);
            check("busy_ready", {30'b0, m1_ready_out, m0_ready_out}, 32'd0);
            if (perturb && i == 0) begin
                m0_valid_in = 1'b0;
                m1_valid_in = 1'b0;
                m0_addr_in  = $urandom;
                m1_addr_in  = $urandom;
            end
            mem_ready_in = (i == waits);
            mem_data_in  = (i == waits) ? rdata : $urandom;
            @(negedge clock_in);
        end
        exp_resp = tmo ? 32'd0 : rdata;
        check("resp_ready0", {31'b0, m0_ready_out}, (win == 0) ? 32'd1 : 32'd0);
        check("resp_ready1", {31'b0, m1_ready_out}, (win == 1) ? 32'd1 : 32'd0);
        check("resp_err0", {31'b0, m0_err_out}, (win == 0 && tmo) ? 32'd1 : 32'd0);
        check("resp_err1", {31'b0, m1_err_out}, (win == 1 && tmo) ? 32'd1 : 32'd0);
        check("resp_data0", m0_data_out, exp_resp);
        check("resp_data1", m1_data_out, exp_resp);
        check("resp_mem_valid", {31'b0, mem_valid_out}, 32'd0);
        $display("txn v0=%0d v1=%0d owner=m%0d waits=%0d timeout=%0d data=%h", v0, v1, win, waits, tmo, exp_resp);
        exp_last     = win;
        m0_valid_in  = 1'b0;
        m1_valid_in  = 1'b0;
        mem_ready_in = late;
        mem_data_in  = 32'hBAD0_BAD0;
        @(negedge clock_in);
        mem_ready_in = 1'b0;
    endtask

    initial begin
        int sel;
        int r;
        int w;
        reset_in     = 1'b1;
        m0_valid_in  = 1'b0;
        m1_valid_in  = 1'b0;
        m0_addr_in   = '0;
        m1_addr_in   = '0;
        mem_ready_in = 1'b0;
        mem_data_in  = '0;
        #1;
        check("rst_mem_valid", {31'b0, mem_valid_out}, 32'd0);
        check("rst_mem_addr", mem_addr_out, 32'd0);
        check("rst_ready", {30'b0, m1_ready_out, m0_ready_out}, 32'd0);
        check("rst_err", {30'b0, m1_err_out, m0_err_out}, 32'd0);
        check("rst_data", m0_data_out | m1_data_out, 32'd0);
        repeat (2) @(negedge clock_in);
        reset_in = 1'b0;
        @(negedge clock_in);

        // m0 alone, zero wait
        do_txn(1, 0, 32'h40, 32'h0, 0, 32'hDEAD_BEEF, 0, 0);
        // continuous tie: alternating grants
        for (int k = 0; k < 4; k++) do_txn(1, 1, 32'h10, 32'h20, 0, 32'h100 + k, 0, 0);
        // m1 with 3 wait states
        do_txn(0, 1, 32'h0, 32'h80, 3, 32'h1234_5678, 0, 0);
        // timeout with late answer, then a normal access
        do_txn(1, 0, 32'h44, 32'h0, 100, 32'h0, 0, 1);
        do_txn(1, 0, 32'h48, 32'h0, 1, 32'hCAFE_F00D, 0, 0);
        // ready coincides with the final watchdog cycle
        do_txn(0, 1, 32'h0, 32'h90, TIMEOUT - 1, 32'h5A5A_A5A5, 0, 0);

        // asynchronous reset while BUSY
        m0_valid_in = 1'b1;
        m1_valid_in = 1'b1;
        m0_addr_in  = 32'h100;
        m1_addr_in  = 32'h200;
        @(negedge clock_in);
        check("pre_rst_busy", {31'b0, mem_valid_out}, 32'd1);
        #2 reset_in = 1'b1;
        #1;
        check("async_rst_mem_valid", {31'b0, mem_valid_out}, 32'd0);
        check("async_rst_mem_addr", mem_addr_out, 32'd0);
        m0_valid_in = 1'b0;
        m1_valid_in = 1'b0;
        @(negedge clock_in);
        reset_in = 1'b0;
        exp_last = 1;
        exp_resp = '0;
        for (int k = 0; k < 3; k++) begin
            check("post_rst_no_ready", {30'b0, m1_ready_out, m0_ready_out}, 32'd0);
            @(negedge clock_in);
        end
        do_txn(1, 1, 32'h300, 32'h400, 0, 32'h7777_0001, 0, 0);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(1, 3);
            r   = $urandom_range(0, 9);
            if (r < 6)       w = $urandom_range(0, 3);
            else if (r == 6) w = TIMEOUT - 1;
            else if (r == 7) w = TIMEOUT;
            else             w = $urandom_range(0, 8);
            do_txn(sel[0], sel[1], $urandom, $urandom, w, $urandom,
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit exceeded");
        $fatal(1, "time limit");
    end
endmodule
